// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel word handshake into the bit serializer.
// The master offers in_data and qualifies it with in_valid. The slave (the
// serializer) answers with in_ready. A word transfers on a rising edge
// where in_valid and in_ready are both high.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: turns parallel words into a framed serial bit stream.
//
// Data path:
//   - A one-entry holding register takes each word.
//   - The word then moves into a shift register.
//   - Bits leave one per enabled cycle. MSB_FIRST selects the bit order.
//   - A frame is WIDTH bits long.
//
// Back-to-back words reload on the last bit, so there is no idle gap
// between frames. serial_out, serial_valid and frame_start are registered.
// They are computed from next-state values, so they always describe the
// bit that the shift register is presenting in the current cycle.
//
// Optional feature (macro BIT_SERIALIZER_PARITY_EN):
//   - Each frame gets one extra bit at the end.
//   - That bit is an even-parity bit (XOR of the data bits).
//   - The frame becomes WIDTH+1 bits long.
//   - Leave the macro undefined for plain WIDTH-bit frames. No parity
//     logic is built in that case.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    bit_serializer_if.slave   in_if,
    input  logic              serial_en,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              frame_start,
    output logic              busy
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);

    // Two-bit encoding, so that unused codes exist and can be steered
    // back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             frame_start_q, frame_start_d;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             in_ready_w;
    logic             accept_w;
    logic             drain_w;
    logic             last_bit_w;
    logic [WIDTH-1:0] shift_adv_w;
    logic             cur_bit_w;

    // The holding register accepts a word whenever it is empty. It is
    // forced low while reset is held so that nothing is taken during reset.
    assign in_ready_w     = ~hold_full_q & ~reset;
    assign in_if.in_ready = in_ready_w;
    assign accept_w       = in_if.in_valid & in_ready_w;
    assign last_bit_w     = (cnt_q == CW'(FRAME_LEN - 1));

    // Shift register advance: the bit that was just emitted is dropped
    // and the next bit moves into the output position.
    assign shift_adv_w = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shift_q[WIDTH-1:1]};

    // Next-state logic for the FSM, the holding register and the
    // registered serial outputs.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        drain_w     = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_SHIFT;
                    shift_d = hold_q;
                    cnt_d   = '0;
                    drain_w = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
                    parity_d = ^hold_q;
`endif
                end
            end
            ST_SHIFT: begin
                if (serial_en) begin
                    if (last_bit_w) begin
                        if (hold_full_q) begin
                            // Reload on the last bit so the next frame
                            // follows with no gap.
                            shift_d = hold_q;
                            cnt_d   = '0;
                            drain_w = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
                            parity_d = ^hold_q;
`endif
                        end else begin
                            state_d = ST_IDLE;
                            shift_d = '0;
                            cnt_d   = '0;
                        end
                    end else begin
                        shift_d = shift_adv_w;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase

        // The holding register only accepts a word when it is empty. A
        // load and a drain of the same word therefore never coincide, and
        // a drain always frees the entry for the next cycle.
        if (accept_w) begin
            hold_d      = in_if.in_data;
            hold_full_d = 1'b1;
        end else if (drain_w) begin
            hold_full_d = 1'b0;
        end
    end

    // Bit presented next cycle: either a data bit from the shift register
    // or, after all data bits, the parity bit.
    always_comb begin
        cur_bit_w = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
`ifdef BIT_SERIALIZER_PARITY_EN
        if (cnt_d == CW'(WIDTH)) begin
            cur_bit_w = parity_d;
        end
`endif
    end

    // Registered outputs derived from the next state. While stalled,
    // every next-state value equals the current one, so the outputs hold.
    always_comb begin
        serial_valid_d = (state_d == ST_SHIFT);
        frame_start_d  = (state_d == ST_SHIFT) && (cnt_d == '0);
        serial_out_d   = (state_d == ST_SHIFT) && cur_bit_w;
    end

    // State register. Reset is asynchronous: it clears the state, the
    // holding register, the shift register, the counter and all outputs
    // as soon as it rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            shift_q        <= '0;
            cnt_q          <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_start_q  <= frame_start_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_start  = frame_start_q;
    assign busy         = (state_q == ST_SHIFT) | hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed vectors with hand-computed bit streams.
// The bench has two instances:
//   - u_dut  : WIDTH=8, MSB-first.
//   - u_dut2 : WIDTH=8, LSB-first.
// The parity frame tests are compiled in only when BIT_SERIALIZER_PARITY_EN
// is defined.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic clk;
    logic reset;
    logic serial_en;
    logic s_out, s_valid, f_start, s_busy;
    logic s2_out, s2_valid, f2_start, s2_busy;

    int vec_cnt  = 0;
    int miscomp  = 0;

    bit_serializer_if #(.WIDTH(8)) u_if  ();
    bit_serializer_if #(.WIDTH(8)) u_if2 ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_if        (u_if.slave),
        .serial_en    (serial_en),
        .serial_out   (s_out),
        .serial_valid (s_valid),
        .frame_start  (f_start),
        .busy         (s_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .in_if        (u_if2.slave),
        .serial_en    (serial_en),
        .serial_out   (s2_out),
        .serial_valid (s2_valid),
        .frame_start  (f2_start),
        .busy         (s2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected bit idx of a frame. Index 8 is the even-parity bit.
    function automatic logic exp_bit(input logic [7:0] w, input int idx, input bit msb);
        if (idx >= 8) return ^w;
        return msb ? w[7 - idx] : w[idx];
    endfunction

    // Offer one word to u_dut. Returns 1 ns after the accepting edge.
    task automatic send_word(input logic [7:0] d);
        int n = 0;
        while (!u_if.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_wait", 32'(u_if.in_ready), 32'd1);
        u_if.in_data  = d;
        u_if.in_valid = 1'b1;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
    endtask

    // Send one word and check the whole frame. Afterwards the DUT must
    // be back in IDLE.
    task automatic run_frame(input logic [7:0] d);
        send_word(d);
        for (int i = 0; i < FLEN; i++) begin
            @(posedge clk); #1;
            chk($sformatf("frm%02h_v%0d", d, i),  32'(s_valid), 32'd1);
            chk($sformatf("frm%02h_b%0d", d, i),  32'(s_out),   32'(exp_bit(d, i, 1'b1)));
            chk($sformatf("frm%02h_fs%0d", d, i), 32'(f_start), 32'(i == 0));
            $display("frame %02h bit %0d: out=%0d fs=%0d", d, i, s_out, f_start);
        end
        @(posedge clk); #1;
        chk($sformatf("frm%02h_idle_v", d), 32'(s_valid), 32'd0);
        chk($sformatf("frm%02h_idle_b", d), 32'(s_busy),  32'd0);
    endtask

    initial begin
        int idx;
        int cyc;
        int vcount;
        logic [7:0] w;

        reset          = 1'b0;
        serial_en      = 1'b1;
        u_if.in_data   = '0;
        u_if.in_valid  = 1'b0;
        u_if2.in_data  = '0;
        u_if2.in_valid = 1'b0;

        // Reset state
        #3 reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(u_if.in_ready), 32'd0);
        chk("rst_out",   32'(s_out),         32'd0);
        chk("rst_valid", 32'(s_valid),       32'd0);
        chk("rst_fs",    32'(f_start),       32'd0);
        chk("rst_busy",  32'(s_busy),        32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(u_if.in_ready), 32'd1);
        $display("reset released");

        // Single word B4, MSB first: 1,0,1,1,0,1,0,0
        run_frame(8'hB4);

        // Two back-to-back words FF then 00: 2*FLEN contiguous valid bits
        u_if.in_data  = 8'hFF;
        u_if.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_hold_full_ready", 32'(u_if.in_ready), 32'd0);
        u_if.in_data = 8'h00;
        for (int i = 0; i < 2 * FLEN; i++) begin
            @(posedge clk); #1;
            w = (i < FLEN) ? 8'hFF : 8'h00;
            chk($sformatf("b2b_v%0d", i),  32'(s_valid), 32'd1);
            chk($sformatf("b2b_b%0d", i),  32'(s_out),   32'(exp_bit(w, i % FLEN, 1'b1)));
            chk($sformatf("b2b_fs%0d", i), 32'(f_start), 32'(i == 0 || i == FLEN));
            if (i == 1) begin
                chk("b2b_both_full_ready", 32'(u_if.in_ready), 32'd0);
                u_if.in_valid = 1'b0;
            end
            $display("b2b bit %0d: out=%0d fs=%0d", i, s_out, f_start);
        end
        @(posedge clk); #1;
        chk("b2b_idle_v", 32'(s_valid), 32'd0);

        // Stall mid-frame on A5: serial_en pattern 1,1,0,0,1,... per cycle
        send_word(8'hA5);
        idx = 0;
        cyc = 0;
        while (idx < FLEN && cyc < 40) begin
            @(posedge clk); #1;
            serial_en = (cyc == 2 || cyc == 3) ? 1'b0 : 1'b1;
            chk($sformatf("stall_v%0d", cyc),  32'(s_valid), 32'd1);
            chk($sformatf("stall_b%0d", cyc),  32'(s_out),   32'(exp_bit(8'hA5, idx, 1'b1)));
            chk($sformatf("stall_fs%0d", cyc), 32'(f_start), 32'(idx == 0));
            $display("stall cyc %0d en=%0d: out=%0d bit %0d", cyc, serial_en, s_out, idx);
            if (serial_en) idx++;
            cyc++;
        end
        serial_en = 1'b1;
        chk("stall_len", 32'(cyc), 32'(FLEN + 2));
        @(posedge clk); #1;
        chk("stall_idle_v", 32'(s_valid), 32'd0);

        // Reset after 3 bits of C3: outputs drop at once, nothing follows
        send_word(8'hC3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rstmid_b%0d", i), 32'(s_out), 32'(exp_bit(8'hC3, i, 1'b1)));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rstmid_out",   32'(s_out),         32'd0);
        chk("rstmid_valid", 32'(s_valid),       32'd0);
        chk("rstmid_fs",    32'(f_start),       32'd0);
        chk("rstmid_busy",  32'(s_busy),        32'd0);
        chk("rstmid_ready", 32'(u_if.in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (s_valid) vcount++;
        end
        chk("rstmid_no_tail", 32'(vcount), 32'd0);
        $display("post-reset valid cycles: %0d", vcount);

`ifdef BIT_SERIALIZER_PARITY_EN
        // Parity frames: 07 -> parity 1, 03 -> parity 0
        run_frame(8'h07);
        run_frame(8'h03);
`endif

        // LSB first on 01: 1 then seven 0s
        chk("lsb_ready", 32'(u_if2.in_ready), 32'd1);
        u_if2.in_data  = 8'h01;
        u_if2.in_valid = 1'b1;
        @(posedge clk); #1;
        u_if2.in_valid = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            @(posedge clk); #1;
            chk($sformatf("lsb_v%0d", i),  32'(s2_valid), 32'd1);
            chk($sformatf("lsb_b%0d", i),  32'(s2_out),   32'(exp_bit(8'h01, i, 1'b0)));
            chk($sformatf("lsb_fs%0d", i), 32'(f2_start), 32'(i == 0));
            $display("lsb bit %0d: out=%0d", i, s2_out);
        end
        @(posedge clk); #1;
        chk("lsb_idle_v", 32'(s2_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted out first, 0 = LSB first.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 serial_en  input  1  bit-advance enable; low = stall, all serial outputs hold.
REQ-009 serial_out  output  1  serial bit stream; feeds the downstream detector's data_in.
REQ-010 serial_valid  output  1  serial_out carries a frame bit this cycle.
REQ-011 frame_start  output  1  high during the first bit of each frame.
REQ-012 busy  output  1  shift register or holding register occupied.

Function
REQ-013 Word transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into a one-entry holding register.
REQ-014 in_ready SHALL be 1 when the holding register is empty, combinationally independent of in_valid.
REQ-015 FSM states SHALL be IDLE and SHIFT; other encodings SHALL return to IDLE.
REQ-016 IDLE -> SHIFT when the holding register is full; the holding register moves into the shift register and the bit counter clears to 0.
REQ-017 In SHIFT, when serial_en=1, one bit SHALL be emitted per cycle in order per MSB_FIRST and the bit counter SHALL increment; when serial_en=0, serial_out, serial_valid, counter and shift register SHALL hold.
REQ-018 Frame length SHALL be WIDTH bits (WIDTH+1 with PARITY_EN).
REQ-019 On the last bit of a frame with serial_en=1: if the holding register is full, reload and stay in SHIFT with no idle gap; otherwise go to IDLE.
REQ-020 A word accepted in cycle N while IDLE SHALL present its first bit on serial_out at cycle N+2 (holding register, then shift register), with serial_valid=1 and frame_start=1.
REQ-021 Holding-register load and holding-register drain into the shift register in the same cycle SHALL both succeed; no word is lost or duplicated.
REQ-022 When serial_valid=0, serial_out SHALL be 0.
REQ-023 busy = (state==SHIFT) OR holding register full.

Reset
REQ-024 reset=1 SHALL immediately force state IDLE, holding register empty, bit counter 0 and shift register 0.
REQ-025 While reset=1: in_ready=0, serial_out=0, serial_valid=0, frame_start=0, busy=0.
REQ-026 Reset mid-frame SHALL discard the partial frame and any held word; the first frame after reset SHALL start only from a newly accepted word.

Configuration
REQ-027 Macro BIT_SERIALIZER_PARITY_EN defined: an even-parity bit (XOR of the WIDTH data bits) SHALL be appended as bit WIDTH+1 with serial_valid=1 and frame_start=0.
REQ-028 Macro BIT_SERIALIZER_PARITY_EN undefined: no parity bit; parity logic SHALL be absent.

Verification
REQ-029 Reset, then WIDTH=8, MSB_FIRST=1, in_data=8'hB4 with serial_en=1 -> serial_out 1,0,1,1,0,1,0,0 on consecutive cycles; frame_start on the first bit only; IDLE afterwards.
REQ-030 Two words 8'hFF and 8'h00 offered back-to-back -> 16 contiguous serial_valid cycles with no gap; frame_start on bits 1 and 9; in_ready low while both registers are full.
REQ-031 serial_en toggled 1,0,0,1 mid-frame on 8'hA5 -> bit sequence unchanged, outputs frozen for 2 cycles, frame 2 cycles longer.
REQ-032 reset asserted after 3 bits of 8'hC3 -> outputs 0 in the same cycle; no remaining bits of 8'hC3 emitted after release.
REQ-033 With BIT_SERIALIZER_PARITY_EN, in_data=8'h07 -> 9-bit frame 0,0,0,0,0,1,1,1,1 (parity 1); with 8'h03 -> parity bit 0.
REQ-034 MSB_FIRST=0, in_data=8'h01 -> first serial bit 1, then seven 0s.
